// File: rtl/store_queue_pkg.sv
// Shared encodings for the store queue: store-op sizes and flush FSM states.
package store_queue_pkg;

    typedef enum logic [2:0] {
        ST_NONE = 3'b000,
        ST_B    = 3'b001,
        ST_H    = 3'b010,
        ST_W    = 3'b011,
        ST_D    = 3'b100
    } st_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sq_state_t;

    // Access size in bytes; 0 means the op does not store anything.
    function automatic logic [3:0] op_bytes(input logic [2:0] op);
        case (op)
            ST_B:    op_bytes = 4'd1;
            ST_H:    op_bytes = 4'd2;
            ST_W:    op_bytes = 4'd4;
            ST_D:    op_bytes = 4'd8;
            default: op_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/store_queue_if.sv
// Memory write port between the store queue (master) and the data memory (slave).
interface store_queue_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic            m_valid;
    logic            m_ready;
    logic [AW-1:0]   m_addr;
    logic [DW/8-1:0] m_byteen;
    logic [DW-1:0]   m_wdata;

    modport master (
        output m_valid, m_addr, m_byteen, m_wdata,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_addr, m_byteen, m_wdata,
        output m_ready
    );
endinterface

// File: rtl/store_lane_align.sv
// Combinational lane placement of a store: byte enables, shifted data and
// misalignment detection for a DW-bit memory word.
module store_lane_align
    import store_queue_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                     st_valid,
    input  logic [2:0]               st_op,
    input  logic [$clog2(DW/8)-1:0]  off,
    input  logic [DW-1:0]            st_data,
    output logic [DW/8-1:0]          byteen,
    output logic [DW-1:0]            wdata,
    output logic                     legal,
    output logic                     align_err
);

    localparam int NB = DW / 8;

    logic [3:0]    size;
    logic [3:0]    off4;
    logic          fits;
    logic [NB-1:0] be_raw;
    logic [DW-1:0] keep;

    always_comb begin
        size   = op_bytes(st_op);
        off4   = 4'(off);
        // Natural alignment plus the access must not be wider than the bus.
        fits   = ((off4 & (size - 4'd1)) == 4'd0) && (size <= 4'(NB));
        legal  = (size != 4'd0) && fits;
        align_err = st_valid && (size != 4'd0) && !fits;

        be_raw = '0;
        keep   = '0;
        for (int j = 0; j < NB; j++) begin
            if (j < int'(size)) begin
                be_raw[j]      = 1'b1;
                keep[8*j +: 8] = st_data[8*j +: 8];
            end
        end

        byteen = legal ? (be_raw << off) : '0;
        wdata  = legal ? (keep << {off, 3'b000}) : '0;
    end

endmodule

// File: rtl/store_queue.sv
// Store queue between MEM and the data memory port: lane alignment, a DEPTH-entry
// FIFO drained over valid/ready, load-conflict detection and a flush/drain FSM.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [2:0]    st_op,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          align_err,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_conflict,
    store_queue_if.master mem,
    input  logic          flush_req,
    output logic          flush_done,
    output logic          empty
);

    localparam int NB   = DW / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [NB-1:0] be_q   [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    sq_state_t     state;

    logic          legal;
    logic [NB-1:0] al_byteen;
    logic [DW-1:0] al_wdata;
    logic [AW-1:0] st_base, ld_base;
    logic          full, enq, deq;

    store_lane_align #(.DW(DW)) u_align (
        .st_valid  (st_valid),
        .st_op     (st_op),
        .off       (st_addr[OFFW-1:0]),
        .st_data   (st_data),
        .byteen    (al_byteen),
        .wdata     (al_wdata),
        .legal     (legal),
        .align_err (align_err)
    );

    assign st_base    = {st_addr[AW-1:OFFW], {OFFW{1'b0}}};
    assign ld_base    = {ld_addr[AW-1:OFFW], {OFFW{1'b0}}};
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign st_ready   = !full && (state == IDLE);
    assign enq        = st_valid && st_ready && legal;
    assign deq        = mem.m_valid && mem.m_ready;
    assign count_next = count + CW'(enq) - CW'(deq);

    // Head is presented straight from storage; there is no enqueue bypass.
    assign mem.m_valid  = !empty;
    assign mem.m_addr   = addr_q[rd_ptr];
    assign mem.m_byteen = be_q[rd_ptr];
    assign mem.m_wdata  = data_q[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                be_q[i]   <= '0;
                data_q[i] <= '0;
            end
            vld_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // enq needs !full and deq needs !empty, so the two slots never coincide.
            if (deq) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (enq) begin
                addr_q[wr_ptr] <= st_base;
                be_q[wr_ptr]   <= al_byteen;
                data_q[wr_ptr] <= al_wdata;
                vld_q[wr_ptr]  <= 1'b1;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == ld_base)) ld_conflict = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            flush_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flush_done <= 1'b0;
                    if (flush_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (count_next == '0) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    flush_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/store_queue.md
# store_queue

Parametrised store path between the MEM stage and the data memory port. It converts a store request into a lane-aligned write word and byte-enable mask, with generic data width and byte/half/word/dword sizes. Misaligned stores are trapped. Accepted stores are buffered in a DEPTH-entry FIFO and drained to memory over a valid/ready handshake. The block also provides load-conflict detection and a flush/drain sequence used before exceptions and `eret`.

## Interface
- DW, 32: data width in bits; 32 or 64.
- AW, 32: address width.
- DEPTH, 4: queue entries; power of two, ≥2.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-low; one clock, async active-low reset, fixed.
- st_valid  input  1  store request present.
- st_ready  output  1  queue can accept this cycle.
- st_op  input  3  000 none, 001 byte, 010 half, 011 word, 100 dword (DW=64 only); others treated as none.
- st_addr  input  AW  byte address.
- st_data  input  DW  store data, right-justified.
- align_err  output  1  misaligned or illegal-size store this cycle.
- ld_addr  input  AW  address of load in MEM.
- ld_conflict  output  1  a queued store targets the same DW-aligned word.
- m_valid  output  1  head entry valid toward memory.
- m_ready  input  1  memory accepts head.
- m_addr  output  AW  DW-aligned address; low log2(DW/8) bits are 0.
- m_byteen  output  DW/8  byte enables.
- m_wdata  output  DW  lane-placed data; unselected lanes 0.
- flush_req  input  1  request drain.
- flush_done  output  1  one-cycle pulse when drained.
- empty  output  1  queue empty.

## Operation
- Size in bytes: S = 1, 2, 4, 8 for op 001–100. Offset: off = st_addr mod (DW/8).
- Misalignment: align_err = st_valid & op≠none & (off mod S ≠ 0 or S > DW/8). This check is combinational. An erroring store is never enqueued.
- Byteen: ((1<<S)−1) << off.
- Wdata: st_data[8S−1:0] << 8·off, with all other bits 0.
- Enqueue when st_valid & st_ready & op≠none & !align_err.
- A none-op request with st_valid is a no-op and is never enqueued.
- Dequeue when m_valid & m_ready. The head outputs come directly from storage.
- st_ready = !full & state==IDLE. At full, simultaneous dequeue does NOT open st_ready in the same cycle.
- Simultaneous enqueue and dequeue (not full, not empty): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- ld_conflict = OR over valid entries of (entry addr == ld_addr with low log2(DW/8) bits cleared). It is combinational and does not include a store being enqueued in the same cycle.
- FSM:
  - IDLE: on flush_req go to DRAIN.
  - DRAIN: st_ready=0. When the queue is empty (count==0 after this cycle's dequeue) go to DONE.
  - DONE: flush_done=1 for one cycle, then IDLE.
  - flush_req while in DRAIN or DONE is ignored.
  - flush_req with the queue already empty: IDLE→DRAIN→DONE, so flush_done arrives 2 cycles after the request.

## Timing
- Reset values: m_valid=0, empty=1, flush_done=0, align_err=0 (with st_valid=0), ld_conflict=0, st_ready=1.
  - Storage, m_addr, m_byteen and m_wdata are all 0. Pointers and count are 0. State is IDLE.
- Reset asserted mid-operation discards all entries immediately. No write reaches memory after reset asserts.
- Latency: a store accepted at edge N presents m_valid=1 after edge N (cycle N+1) when the queue was empty. There is no bypass.
- m_valid, m_addr, m_byteen and m_wdata stay stable while m_valid & !m_ready.
- Throughput: one enqueue and one dequeue per cycle.
- flush_done asserts the cycle after the last dequeue completes.

## Structure
- Shared package: st_op encodings (ST_NONE, ST_B, ST_H, ST_W, ST_D) and the FSM state constants (IDLE, DRAIN, DONE).
- One sub-module, store_lane_align: the combinational byteen/wdata/align_err generator, parametrised by DW. The top level holds the FIFO, pointers, conflict compare and FSM.

## Test plan
- Byte stores, DW=32: addresses 0x100..0x103 with data 0xAB → byteen 0001/0010/0100/1000, wdata 0x000000AB/0x0000AB00/0x00AB0000/0xAB000000, m_addr 0x100 throughout.
- Misaligned stores: half at 0x101, word at 0x102, dword when DW=32 → align_err=1, nothing enqueued, empty stays 1. With DW=64, dword at 0x08 → byteen 0xFF.
- Backpressure: m_ready=0 with DEPTH=4 stores → st_ready=0 after the 4th. A 5th store is held with enqueue blocked. Releasing m_ready drains the entries in order with stable outputs.
- Simultaneous enqueue/dequeue, plus pointer wrap over 10 stores with m_ready=1 → memory sees the exact input order and count never exceeds 1.
- Conflict: word store to 0x200 queued with m_ready=0; ld_addr=0x202 → ld_conflict=1; ld_addr=0x204 → 0.
- Flush with 3 entries queued and m_ready=1 → st_ready=0 for 3 cycles, then flush_done pulses 1 cycle. Asserting reset during DRAIN clears the queue and returns to IDLE with no flush_done.
